// File: rtl/pmp_checker.sv
// pmp_checker: RISC-V physical memory protection checker.
//
// Holds NUM_ENTRIES pmpcfg/pmpaddr CSR pairs and checks each memory request
// (whole byte range, start to end) against them. A result is registered one
// cycle after acceptance and held until the consumer takes it. The first
// denied response to be transferred is captured in sticky fault registers.
//
// Ports:
//   clock, reset        system clock, synchronous active-low reset
//   priv_mode           2'b00 = machine mode, anything else = less privileged
//   csr_wr_en/addr/wdata/rdata  CSR access port (rdata is combinational)
//   req_valid/ready/addr/size/oper  check request
//   rsp_valid/ready/allow/hit/entry result
//   fault_valid, fault_addr         sticky first-fault capture
//
// Optional build macro PMP_FAULT_CNT_EN adds a saturating 16-bit count of
// denied responses, readable and clearable at CSR FAULT_CSR+1.
module pmp_checker #(
  parameter int          NUM_ENTRIES = 16,
  parameter logic [11:0] FAULT_CSR   = 12'h3C0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  priv_mode,
  input  logic        csr_wr_en,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [1:0]  req_oper,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_allow,
  output logic        rsp_hit,
  output logic [3:0]  rsp_entry,
  output logic        fault_valid,
  output logic [31:0] fault_addr
);

  localparam logic [11:0] CFG_BASE  = 12'h3A0;
  localparam logic [11:0] ADDR_BASE = 12'h3B0;
  localparam logic [1:0]  A_TOR     = 2'd1;
  localparam logic [1:0]  A_NA4     = 2'd2;
  localparam logic [1:0]  A_NAPOT   = 2'd3;

  logic [7:0]  cfg_r  [NUM_ENTRIES];
  logic [31:0] addr_r [NUM_ENTRIES];

  logic        rsp_valid_r, rsp_allow_r, rsp_hit_r;
  logic [3:0]  rsp_entry_r;
  logic [31:0] rsp_addr_r;
  logic        fault_valid_r;
  logic [31:0] fault_addr_r;
  logic [3:0]  fault_entry_r;

  logic        csr_we_s, fault_clr_s, req_fire_s, deny_xfer_s;
  logic [NUM_ENTRIES-1:0] addr_lock_s, in_a_s, in_e_s;
  logic [31:0] prev_s [NUM_ENTRIES];
  logic [33:0] a_s, e_s;
  logic        match_found_s, match_full_s, perm_s, allow_s;
  logic [3:0]  match_idx_s;
  logic [7:0]  match_cfg_s;
  logic [31:0] rdata_s;

  // Stored cfg form: bits 6:5 forced to 0, and W without R is dropped.
  function automatic logic [7:0] legal_cfg(input logic [7:0] w);
    logic [7:0] v;
    v    = {w[7], 2'b00, w[4:0]};
    v[1] = v[1] & v[0];
    return v;
  endfunction

  // Does byte address x fall inside the region of one entry?
  function automatic logic in_region(input logic [1:0] mode, input logic [31:0] cur,
                                     input logic [31:0] prv, input logic [33:0] x);
    logic [31:0] napot_mask;
    logic        found;
    // cur ^ (cur+1) sets the trailing ones plus the first zero: the k+1
    // word-address bits that vary inside a NAPOT region.
    napot_mask = cur ^ (cur + 32'd1);
    case (mode)
      A_TOR:   found = (x >= {prv, 2'b00}) && (x < {cur, 2'b00});
      A_NA4:   found = (x[33:2] == cur);
      A_NAPOT: found = ((x[33:2] ^ cur) & ~napot_mask) == 32'd0;
      default: found = 1'b0;
    endcase
    return found;
  endfunction

  assign csr_we_s    = csr_wr_en && (priv_mode == 2'b00);
  assign fault_clr_s = csr_we_s && (csr_addr == FAULT_CSR);
  assign req_ready   = !rsp_valid_r || rsp_ready;
  assign req_fire_s  = req_valid && req_ready;
  assign deny_xfer_s = rsp_valid_r && rsp_ready && !rsp_allow_r;

  // pmpaddr write protection: own lock, or the next entry is a locked TOR top.
  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      addr_lock_s[i] = cfg_r[i][7];
    end
    for (int i = 0; i < NUM_ENTRIES - 1; i++) begin
      addr_lock_s[i] = addr_lock_s[i] | (cfg_r[i+1][7] & (cfg_r[i+1][4:3] == A_TOR));
    end
  end

  // Range check of the access start/end against every entry, lowest index wins.
  always_comb begin
    a_s           = {2'b00, req_addr};
    e_s           = a_s + ((34'd1 << req_size) - 34'd1);
    match_found_s = 1'b0;
    match_full_s  = 1'b0;
    match_idx_s   = 4'd0;
    match_cfg_s   = 8'd0;
    prev_s[0]     = 32'd0;
    for (int i = 1; i < NUM_ENTRIES; i++) begin
      prev_s[i] = addr_r[i-1];
    end
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      in_a_s[i] = in_region(cfg_r[i][4:3], addr_r[i], prev_s[i], a_s);
      in_e_s[i] = in_region(cfg_r[i][4:3], addr_r[i], prev_s[i], e_s);
    end
    // Descending scan so the lowest matching index is the last one written.
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      match_idx_s   = (in_a_s[i] | in_e_s[i]) ? 4'(i) : match_idx_s;
      match_cfg_s   = (in_a_s[i] | in_e_s[i]) ? cfg_r[i] : match_cfg_s;
      match_full_s  = (in_a_s[i] | in_e_s[i]) ? (in_a_s[i] & in_e_s[i]) : match_full_s;
      match_found_s = match_found_s | in_a_s[i] | in_e_s[i];
    end
  end

  // Permission decision for the current request.
  always_comb begin
    case (req_oper)
      2'd0:    perm_s = match_cfg_s[0];
      2'd1:    perm_s = match_cfg_s[1];
      2'd2:    perm_s = match_cfg_s[2];
      default: perm_s = 1'b0;
    endcase
    if (req_size == 2'd3 || req_oper == 2'd3) begin
      allow_s = 1'b0;
    end else if (match_found_s) begin
      if (!match_full_s) begin
        allow_s = 1'b0;
      end else if (priv_mode != 2'b00 || match_cfg_s[7]) begin
        allow_s = perm_s;
      end else begin
        allow_s = 1'b1;
      end
    end else begin
      allow_s = (priv_mode == 2'b00);
    end
  end

  // CSR storage: pmpcfg bytes and pmpaddr words with lock protection.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        cfg_r[i]  <= 8'd0;
        addr_r[i] <= 32'd0;
      end
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (csr_we_s && csr_addr == CFG_BASE + 12'(i / 4) && !cfg_r[i][7]) begin
          cfg_r[i] <= legal_cfg(csr_wdata[8*(i%4) +: 8]);
        end
        if (csr_we_s && csr_addr == ADDR_BASE + 12'(i) && !addr_lock_s[i]) begin
          addr_r[i] <= {2'b00, csr_wdata[29:0]};
        end
      end
    end
  end

  // Response register: loaded on acceptance, held until the consumer takes it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rsp_valid_r <= 1'b0;
      rsp_allow_r <= 1'b0;
      rsp_hit_r   <= 1'b0;
      rsp_entry_r <= 4'd0;
      rsp_addr_r  <= 32'd0;
    end else if (req_fire_s) begin
      rsp_valid_r <= 1'b1;
      rsp_allow_r <= allow_s;
      rsp_hit_r   <= match_found_s;
      rsp_entry_r <= match_idx_s;
      rsp_addr_r  <= req_addr;
    end else if (rsp_ready) begin
      rsp_valid_r <= 1'b0;
    end
  end

  // First-fault capture; a fault arriving with a clear wins over the clear.
  always_ff @(posedge clock) begin
    if (!reset) begin
      fault_valid_r <= 1'b0;
      fault_addr_r  <= 32'd0;
      fault_entry_r <= 4'd0;
    end else if (deny_xfer_s && (!fault_valid_r || fault_clr_s)) begin
      fault_valid_r <= 1'b1;
      fault_addr_r  <= rsp_addr_r;
      fault_entry_r <= rsp_entry_r;
    end else if (fault_clr_s) begin
      fault_valid_r <= 1'b0;
    end
  end

`ifdef PMP_FAULT_CNT_EN
  logic [15:0] fault_cnt_r;

  // Saturating count of denied transfers; a clear with a denial restarts at 1.
  always_ff @(posedge clock) begin
    if (!reset) begin
      fault_cnt_r <= 16'd0;
    end else if (csr_we_s && csr_addr == FAULT_CSR + 12'd1) begin
      fault_cnt_r <= deny_xfer_s ? 16'd1 : 16'd0;
    end else if (deny_xfer_s && fault_cnt_r != 16'hFFFF) begin
      fault_cnt_r <= fault_cnt_r + 16'd1;
    end
  end
`endif

  // CSR read mux; unmapped addresses return 0.
  always_comb begin
    rdata_s = 32'd0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      rdata_s = rdata_s | ((csr_addr == CFG_BASE + 12'(i / 4)) ?
                           (32'(cfg_r[i]) << (8 * (i % 4))) : 32'd0);
      rdata_s = rdata_s | ((csr_addr == ADDR_BASE + 12'(i)) ? addr_r[i] : 32'd0);
    end
    rdata_s = rdata_s | ((csr_addr == FAULT_CSR) ?
                         {fault_valid_r, 27'd0, fault_entry_r} : 32'd0);
`ifdef PMP_FAULT_CNT_EN
    rdata_s = rdata_s | ((csr_addr == FAULT_CSR + 12'd1) ? {16'd0, fault_cnt_r} : 32'd0);
`endif
  end

  assign csr_rdata   = rdata_s;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_allow   = rsp_allow_r;
  assign rsp_hit     = rsp_hit_r;
  assign rsp_entry   = rsp_entry_r;
  assign fault_valid = fault_valid_r;
  assign fault_addr  = fault_addr_r;

endmodule

// File: tb/tb_pmp_checker.sv
// Self-checking bench for pmp_checker (default parameters).
// A region-based reference model is advanced at each rising edge; a compare
// process checks every output against it on each falling edge. Directed
// scenarios add literal expectations, followed by randomized traffic.
module tb_pmp_checker;
  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  priv_mode;
  logic        csr_wr_en;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_size, req_oper;
  logic        rsp_valid, rsp_ready, rsp_allow, rsp_hit;
  logic [3:0]  rsp_entry;
  logic        fault_valid;
  logic [31:0] fault_addr;

  always #5 clock = ~clock;

  pmp_checker dut (
    .clock(clock), .reset(reset), .priv_mode(priv_mode),
    .csr_wr_en(csr_wr_en), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_size(req_size), .req_oper(req_oper),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_allow(rsp_allow),
    .rsp_hit(rsp_hit), .rsp_entry(rsp_entry),
    .fault_valid(fault_valid), .fault_addr(fault_addr)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Reference model state
  logic [7:0]  m_cfg  [16];
  logic [31:0] m_addr [16];
  bit          m_rvalid, m_rallow, m_rhit;
  logic [3:0]  m_rentry;
  logic [31:0] m_raddr;
  bit          m_fv;
  logic [31:0] m_faddr;
  logic [3:0]  m_fentry;
  logic [15:0] m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Inclusive byte bounds of entry i; lo > hi means empty.
  function automatic void region(input int i, output longint lo, output longint hi);
    longint cur, prv, base;
    int k;
    cur = longint'(m_addr[i]);
    prv = 0;
    if (i > 0) prv = longint'(m_addr[i-1]);
    lo = 1;
    hi = 0;
    case (m_cfg[i][4:3])
      2'd1: begin lo = prv * 4; hi = cur * 4 - 1; end
      2'd2: begin lo = cur * 4; hi = lo + 3; end
      2'd3: begin
        k = 0;
        while (k < 32 && m_addr[i][k]) k++;
        base = ((cur >> (k + 1)) << (k + 1)) * 4;
        lo = base;
        hi = base + (longint'(1) << (k + 3)) - 1;
      end
      default: begin lo = 1; hi = 0; end
    endcase
  endfunction

  function automatic void evaluate(input logic [31:0] addr, input logic [1:0] size,
                                   input logic [1:0] oper, input logic [1:0] priv,
                                   output bit hit, output bit allow, output logic [3:0] entry);
    longint a, e, lo, hi;
    bit ina, ine, found;
    a = longint'(addr);
    e = a + (longint'(1) << size) - 1;
    hit = 0; entry = 0; allow = (priv == 2'b00); found = 0;
    for (int i = 0; i < 16; i++) begin
      if (!found) begin
        region(i, lo, hi);
        ina = (a >= lo) && (a <= hi);
        ine = (e >= lo) && (e <= hi);
        if (ina || ine) begin
          found = 1; hit = 1; entry = 4'(i);
          if (!(ina && ine)) allow = 0;
          else if (priv != 2'b00 || m_cfg[i][7]) allow = (oper < 3) ? m_cfg[i][oper] : 1'b0;
          else allow = 1;
        end
      end
    end
    if (size == 2'd3 || oper == 2'd3) allow = 0;
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a);
    logic [31:0] r;
    r = 32'd0;
    if (a >= 12'h3A0 && a < 12'h3A4)
      for (int b = 0; b < 4; b++) r[8*b +: 8] = m_cfg[(a - 12'h3A0) * 4 + b];
    else if (a >= 12'h3B0 && a < 12'h3C0) r = m_addr[a - 12'h3B0];
    else if (a == 12'h3C0) r = {m_fv, 27'd0, m_fentry};
`ifdef PMP_FAULT_CNT_EN
    else if (a == 12'h3C1) r = {16'd0, m_cnt};
`endif
    return r;
  endfunction

  // Advance the model by one clock edge from the inputs seen at that edge.
  task automatic model_step();
    bit nhit, nallow, xfer_deny, mwe, clr, lock, accept;
    logic [3:0] nent;
    logic [7:0] v;
    int idx;
    if (!reset) begin
      for (int i = 0; i < 16; i++) begin m_cfg[i] = 8'd0; m_addr[i] = 32'd0; end
      m_rvalid = 0; m_rallow = 0; m_rhit = 0; m_rentry = 0; m_raddr = 0;
      m_fv = 0; m_faddr = 0; m_fentry = 0; m_cnt = 0;
      return;
    end
    xfer_deny = m_rvalid && rsp_ready && !m_rallow;
    mwe = csr_wr_en && priv_mode == 2'b00;
    clr = mwe && csr_addr == 12'h3C0;
    accept = req_valid && (!m_rvalid || rsp_ready);
    evaluate(req_addr, req_size, req_oper, priv_mode, nhit, nallow, nent);
    if (xfer_deny && (!m_fv || clr)) begin
      m_fv = 1; m_faddr = m_raddr; m_fentry = m_rentry;
    end else if (clr) m_fv = 0;
    if (mwe && csr_addr == 12'h3C1) m_cnt = xfer_deny ? 16'd1 : 16'd0;
    else if (xfer_deny && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    if (mwe && csr_addr >= 12'h3A0 && csr_addr < 12'h3A4) begin
      for (int b = 0; b < 4; b++) begin
        idx = (csr_addr - 12'h3A0) * 4 + b;
        if (!m_cfg[idx][7]) begin
          v = csr_wdata[8*b +: 8];
          v[6:5] = 2'b00;
          if (v[1:0] == 2'b10) v[1] = 1'b0;
          m_cfg[idx] = v;
        end
      end
    end
    if (mwe && csr_addr >= 12'h3B0 && csr_addr < 12'h3C0) begin
      idx = csr_addr - 12'h3B0;
      lock = m_cfg[idx][7];
      if (idx < 15) lock = lock || (m_cfg[idx+1][7] && m_cfg[idx+1][4:3] == 2'd1);
      if (!lock) m_addr[idx] = csr_wdata & 32'h3FFF_FFFF;
    end
    if (accept) begin
      m_rvalid = 1; m_rallow = nallow; m_rhit = nhit; m_rentry = nent; m_raddr = req_addr;
    end else if (rsp_ready) m_rvalid = 0;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clock) begin
    if (cmp_en) begin
      chk("cmp_req_ready", 32'(req_ready), 32'(!m_rvalid || rsp_ready));
      chk("cmp_rsp_valid", 32'(rsp_valid), 32'(m_rvalid));
      if (m_rvalid) begin
        chk("cmp_rsp_allow", 32'(rsp_allow), 32'(m_rallow));
        chk("cmp_rsp_hit",   32'(rsp_hit),   32'(m_rhit));
        chk("cmp_rsp_entry", 32'(rsp_entry), 32'(m_rentry));
      end
      chk("cmp_fault_valid", 32'(fault_valid), 32'(m_fv));
      chk("cmp_fault_addr",  fault_addr, m_faddr);
      chk("cmp_csr_rdata",   csr_rdata, model_read(csr_addr));
    end
  end

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    logic [1:0] sp;
    sp = priv_mode;
    priv_mode = 2'b00; csr_wr_en = 1'b1; csr_addr = a; csr_wdata = d;
    tick();
    csr_wr_en = 1'b0; priv_mode = sp;
  endtask

  task automatic csr_rd_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
    csr_addr = a;
    #1;
    chk(name, csr_rdata, exp);
  endtask

  // Issue one request; on return the response is visible on the outputs.
  task automatic req(input logic [31:0] a, input logic [1:0] s, input logic [1:0] o);
    req_valid = 1'b1; req_addr = a; req_size = s; req_oper = o;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic rsp_chk(input string name, input bit h, input bit al, input logic [3:0] en);
    chk({name, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({name, "_hit"},   32'(rsp_hit),   32'(h));
    chk({name, "_allow"}, 32'(rsp_allow), 32'(al));
    chk({name, "_entry"}, 32'(rsp_entry), 32'(en));
  endtask

  initial begin
    reset = 1'b0; priv_mode = 2'b00; csr_wr_en = 1'b0; csr_addr = 12'd0; csr_wdata = 32'd0;
    req_valid = 1'b0; req_addr = 32'd0; req_size = 2'd0; req_oper = 2'd0; rsp_ready = 1'b1;
    tick();
    cmp_en = 1'b1;
    tick();
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_fault_valid", 32'(fault_valid), 32'd0);
    csr_rd_chk("reset_cfg0", 12'h3A0, 32'd0);
    reset = 1'b1;
    tick();

    // TOR region [0, 0x1000), read only
    csr_wr(12'h3B0, 32'h400);
    csr_wr(12'h3A0, 32'h09);
    priv_mode = 2'b01;
    req(32'h0FFC, 2'd2, 2'd0); rsp_chk("tor_read", 1, 1, 4'd0); tick();
    req(32'h0FFC, 2'd2, 2'd2); rsp_chk("tor_exec", 1, 0, 4'd0); tick();
    chk("fault_first_valid", 32'(fault_valid), 32'd1);
    chk("fault_first_addr", fault_addr, 32'h0FFC);
    req(32'h1000, 2'd2, 2'd0); rsp_chk("tor_miss_u", 0, 0, 4'd0); tick();
    chk("fault_keep_addr", fault_addr, 32'h0FFC);
    csr_rd_chk("fault_csr_read", 12'h3C0, 32'h8000_0000);
    priv_mode = 2'b00;
    req(32'h1000, 2'd2, 2'd0); rsp_chk("tor_miss_m", 0, 1, 4'd0); tick();
    priv_mode = 2'b01;
    csr_wr(12'h3C0, 32'd0);
    chk("fault_cleared", 32'(fault_valid), 32'd0);

    // NAPOT 0x2000-0x3FFF RWX in entry 3
    csr_wr(12'h3B3, 32'h0BFF);
    csr_wr(12'h3A0, 32'h1F00_0009);
    req(32'h3FFC, 2'd2, 2'd0); rsp_chk("napot_top", 1, 1, 4'd3); tick();
    req(32'h3FFE, 2'd2, 2'd0); rsp_chk("napot_partial", 1, 0, 4'd3); tick();

    // Lock: entry 2 NA4 at 0x4000, read only, locked
    csr_wr(12'h3B2, 32'h1000);
    csr_wr(12'h3A0, 32'h1F91_0009);
    csr_wr(12'h3B2, 32'h55);
    csr_rd_chk("lock_addr2", 12'h3B2, 32'h1000);
    csr_wr(12'h3A0, 32'h1F00_0009);
    csr_rd_chk("lock_cfg2", 12'h3A0, 32'h1F91_0009);
    priv_mode = 2'b00;
    req(32'h4000, 2'd0, 2'd1); rsp_chk("lock_m_write", 1, 0, 4'd2); tick();
    req(32'h4000, 2'd0, 2'd0); rsp_chk("lock_m_read", 1, 1, 4'd2); tick();
    priv_mode = 2'b01;

    // Priority: entry 1 (R only) and entry 5 (RWX) both cover 0x8000
    csr_wr(12'h3B1, 32'h21FF);
    csr_wr(12'h3A0, 32'h1F91_1909);
    csr_wr(12'h3B5, 32'h2000);
    csr_wr(12'h3A1, 32'h0000_1700);
    req(32'h8000, 2'd0, 2'd1); rsp_chk("prio_write", 1, 0, 4'd1); tick();
    req(32'h8000, 2'd0, 2'd0); rsp_chk("prio_read", 1, 1, 4'd1); tick();

    // Reserved bits and W-without-R
    csr_wr(12'h3A1, 32'h0060_170A);
    csr_rd_chk("cfg_wr_legal", 12'h3A1, 32'h0000_1708);

    // Back-pressure: payload holds while rsp_ready is low
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h8000; req_size = 2'd0; req_oper = 2'd0;
    tick();
    req_addr = 32'h3FFC; req_size = 2'd2;
    for (int c = 0; c < 3; c++) begin
      chk("stall_req_ready", 32'(req_ready), 32'd0);
      rsp_chk("stall_payload", 1, 1, 4'd1);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    rsp_chk("b2b_second", 1, 1, 4'd3);
    tick();
    chk("drain_valid", 32'(rsp_valid), 32'd0);

    // Reset with a response in flight
    rsp_ready = 1'b0;
    req(32'h0, 2'd0, 2'd0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    rsp_ready = 1'b1;
    chk("rst_mid_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mid_fault", 32'(fault_valid), 32'd0);
    csr_rd_chk("rst_cfg2", 12'h3A0, 32'd0);

`ifdef PMP_FAULT_CNT_EN
    csr_wr(12'h3C1, 32'd0);
    priv_mode = 2'b01;
    for (int n = 0; n < 3; n++) begin
      req(32'h9000, 2'd2, 2'd0);
      tick();
    end
    csr_rd_chk("cnt_three", 12'h3C1, 32'd3);
    csr_wr(12'h3C1, 32'd0);
    csr_rd_chk("cnt_clear", 12'h3C1, 32'd0);
`else
    csr_rd_chk("cnt_absent", 12'h3C1, 32'd0);
`endif

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      int r;
      reset     = ($urandom_range(0, 599) != 0);
      priv_mode = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      csr_wr_en = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 9);
      if (r < 4) begin
        csr_addr  = 12'h3A0 + 12'($urandom_range(0, 3));
        csr_wdata = $urandom;
        if ($urandom_range(0, 15) != 0) csr_wdata = csr_wdata & 32'h7F7F_7F7F;
      end else if (r < 8) begin
        csr_addr  = 12'h3B0 + 12'($urandom_range(0, 15));
        csr_wdata = ($urandom_range(0, 19) == 0) ? $urandom : 32'($urandom_range(0, 'hFFF));
      end else if (r == 8) begin
        csr_addr  = 12'h3C0 + 12'($urandom_range(0, 1));
        csr_wdata = $urandom;
      end else begin
        csr_addr  = 12'($urandom);
        csr_wdata = $urandom;
      end
      req_valid = ($urandom_range(0, 3) != 0);
      req_addr  = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 'h4008));
      req_size  = 2'($urandom_range(0, 3));
      req_oper  = 2'($urandom_range(0, 3));
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
